// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing constants, transmitter state encoding and baud divider helper
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; the head entry is read straight from registered storage
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic wr, rd;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  always_comb begin
    wr = wr_en && !full;
    rd = rd_en && !empty;
    wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = count_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter, LSB first, back-to-back frames
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_tx_byte,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  output logic                          o_tx_serial,
  output logic                          o_tx_busy,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
  localparam int BAUD_DIV = baud_div(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CW = $clog2(BAUD_DIV);
  tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic serial_q, serial_d, done_q, done_d;
  logic full, empty, pop, bit_end, last_bit;
  logic [7:0] rd_data;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .wr_en(i_tx_valid),
    .rd_en(pop),
    .wr_data(i_tx_byte),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .count(o_fifo_count)
  );
  assign bit_end = cnt_q == CW'(BAUD_DIV - 1);
  assign last_bit = bit_q == 3'(UART_DATA_BITS - 1);
  assign o_tx_ready = !full;
  assign o_tx_serial = serial_q;
  assign o_tx_done = done_q;
  assign o_tx_busy = state_q != TX_IDLE || o_fifo_count != '0;
  // Every transition happens on a bit boundary, so the counter is already 0 on state entry.
  always_comb begin
    state_d = state_q;
    cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    serial_d = serial_q;
    pop = 1'b0;
    done_d = state_q == TX_STOP && cnt_q == CW'(BAUD_DIV - 2);
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        serial_d = 1'b1;
        pop = !empty;
      end
      TX_START: if (bit_end) begin
        state_d = TX_DATA;
        bit_d = '0;
        serial_d = shift_q[0];
      end
      TX_DATA: if (bit_end) begin
        state_d = last_bit ? TX_STOP : TX_DATA;
        bit_d = bit_q + 3'd1;
        shift_d = shift_q >> 1;
        serial_d = last_bit ? 1'b1 : shift_q[1];
      end
      TX_STOP: if (bit_end) begin
        state_d = TX_IDLE;
        pop = !empty;
      end
      default: state_d = TX_IDLE;
    endcase
    if (pop) begin
      state_d = TX_START;
      shift_d = rd_data;
      serial_d = 1'b0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= TX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      serial_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      serial_q <= serial_d;
      done_q <= done_d;
    end
  end
endmodule
